// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and fetch stage feeding decode through a small PC/instr FIFO
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [31:0]            imem_addr,
  output logic                   imem_ren,
  input  logic                   imem_nostall,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  input  logic                   id_ready,
  output logic                   id_valid,
  output logic [31:0]            id_instr,
  output logic [31:0]            id_pc,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [31:0]            miss_cycles
);

  localparam int          AW  = $clog2(DEPTH);
  localparam int          CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, FETCH, STALL} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q;
  logic [31:0]   miss_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];
  logic          full, push, pop;

  assign full = (count_q == CW'(DEPTH));

  // A stalled request is held regardless of occupancy: it was only issued while not full.
  always_comb begin
    state_d  = state_q;
    imem_ren = 1'b0;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        imem_ren = !full;
        if (!full && !imem_nostall) state_d = STALL;
      end
      STALL: begin
        imem_ren = 1'b1;
        if (imem_nostall) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid) begin
      imem_ren = 1'b0;
      state_d  = FETCH;
    end
  end

  assign push = imem_ren && imem_nostall;
  assign pop  = id_valid && id_ready && !redirect_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      count_q <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_valid) begin
        pc_q    <= redirect_pc & 32'hFFFF_FFFC;
        count_q <= '0;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
      end else begin
        if (push) begin
          pc_q   <= pc_q + 32'd4;
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= pc_q;
      mem_instr[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miss_q <= '0;
    end else if (imem_ren && !imem_nostall && miss_q != 32'hFFFF_FFFF) begin
      miss_q <= miss_q + 32'd1;
    end
  end

  assign imem_addr   = pc_q;
  assign id_valid    = (count_q != '0);
  assign id_instr    = id_valid ? mem_instr[rd_ptr] : NOP;
  assign id_pc       = id_valid ? mem_pc[rd_ptr] : 32'h0;
  assign fifo_count  = count_q;
  assign miss_cycles = miss_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - bench for instr_fetch_unit: directed table, corner sequences, random vs queue model
module tb_instr_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_ren;
  logic        imem_nostall = 1'b1;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b1;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [2:0]  fifo_count;
  logic [31:0] miss_cycles;
  logic [31:0] mmu_xor = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // MMU stand-in: returns a function of the requested address
  assign imem_rdata = imem_addr ^ mmu_xor;

  instr_fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_ren(imem_ren), .imem_nostall(imem_nostall), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .fifo_count(fifo_count), .miss_cycles(miss_cycles)
  );

  typedef struct {
    logic        nostall, ready, redir;
    logic [31:0] rpc;
    logic        ren;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] hpc;
    int          cnt;
    logic [31:0] miss;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic n, input logic r, input logic d, input logic [31:0] rp,
                     input logic e_ren, input logic [31:0] a, input logic v,
                     input logic [31:0] hp, input int c, input logic [31:0] m);
    vecs.push_back('{n, r, d, rp, e_ren, a, v, hp, c, m});
  endtask

  task automatic cyc(input logic n, input logic r, input logic d, input logic [31:0] rp);
    @(negedge clk);
    imem_nostall   = n;
    id_ready       = r;
    redirect_valid = d;
    redirect_pc    = rp;
    #1;
  endtask

  task automatic chk_head(input string tag, input logic v, input logic [31:0] hpc, input logic [31:0] hin);
    chk({tag, " id_valid"}, {31'b0, id_valid}, {31'b0, v});
    chk({tag, " id_pc"}, id_pc, v ? hpc : 32'h0);
    chk({tag, " id_instr"}, id_instr, v ? hin : 32'h13);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic        m_started, m_pending, e_ren, n, r, d;
    logic [31:0] m_pc, m_miss, rp;
    logic [31:0] qpc[$];
    logic [31:0] qin[$];

    //   nostall ready redir rpc       ren addr          valid head-pc  cnt miss
    add(1, 1, 0, 32'h0,    0, 32'h100,  0, 32'h0,    0, 0);
    add(1, 1, 0, 32'h0,    1, 32'h100,  0, 32'h0,    0, 0);
    add(1, 1, 0, 32'h0,    1, 32'h104,  1, 32'h100,  1, 0);
    add(1, 1, 0, 32'h0,    1, 32'h108,  1, 32'h104,  1, 0);
    add(0, 1, 0, 32'h0,    1, 32'h10C,  1, 32'h108,  1, 0);
    add(0, 1, 0, 32'h0,    1, 32'h10C,  0, 32'h0,    0, 1);
    add(0, 1, 0, 32'h0,    1, 32'h10C,  0, 32'h0,    0, 2);
    add(1, 1, 0, 32'h0,    1, 32'h10C,  0, 32'h0,    0, 3);
    add(1, 0, 0, 32'h0,    1, 32'h110,  1, 32'h10C,  1, 3);
    add(1, 0, 0, 32'h0,    1, 32'h114,  1, 32'h10C,  2, 3);
    add(1, 0, 0, 32'h0,    1, 32'h118,  1, 32'h10C,  3, 3);
    add(1, 0, 0, 32'h0,    0, 32'h11C,  1, 32'h10C,  4, 3);
    add(1, 1, 0, 32'h0,    0, 32'h11C,  1, 32'h10C,  4, 3);
    add(1, 0, 0, 32'h0,    1, 32'h11C,  1, 32'h110,  3, 3);
    add(1, 0, 0, 32'h0,    0, 32'h120,  1, 32'h110,  4, 3);
    add(1, 1, 1, 32'h2003, 0, 32'h120,  1, 32'h110,  4, 3);
    add(1, 1, 0, 32'h0,    1, 32'h2000, 0, 32'h0,    0, 3);
    add(1, 1, 0, 32'h0,    1, 32'h2004, 1, 32'h2000, 1, 3);
    add(0, 1, 0, 32'h0,    1, 32'h2008, 1, 32'h2004, 1, 3);
    add(0, 1, 1, 32'h400,  0, 32'h2008, 0, 32'h0,    0, 4);
    add(1, 1, 0, 32'h0,    1, 32'h400,  0, 32'h0,    0, 4);
    add(1, 1, 0, 32'h0,    1, 32'h404,  1, 32'h400,  1, 4);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset imem_ren", {31'b0, imem_ren}, 32'h0);
    chk("reset imem_addr", imem_addr, 32'h100);
    chk_head("reset", 1'b0, 32'h0, 32'h0);
    chk("reset fifo_count", {29'b0, fifo_count}, 32'h0);
    chk("reset miss_cycles", miss_cycles, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      imem_nostall   = vecs[i].nostall;
      id_ready       = vecs[i].ready;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      #1;
      chk($sformatf("row%0d imem_ren", i), {31'b0, imem_ren}, {31'b0, vecs[i].ren});
      chk($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].addr);
      chk_head($sformatf("row%0d", i), vecs[i].valid, vecs[i].hpc, vecs[i].hpc);
      chk($sformatf("row%0d fifo_count", i), {29'b0, fifo_count}, vecs[i].cnt);
      chk($sformatf("row%0d miss_cycles", i), miss_cycles, vecs[i].miss);
    end

    // PC wraps modulo 2^32
    cyc(1, 1, 1, 32'hFFFF_FFF8);
    chk("wrap redirect ren", {31'b0, imem_ren}, 32'h0);
    cyc(1, 1, 0, 32'h0);
    chk("wrap addr0", imem_addr, 32'hFFFF_FFF8);
    chk_head("wrap c1", 1'b0, 32'h0, 32'h0);
    cyc(1, 1, 0, 32'h0);
    chk("wrap addr1", imem_addr, 32'hFFFF_FFFC);
    chk_head("wrap c2", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFF8);
    cyc(1, 1, 0, 32'h0);
    chk("wrap addr2", imem_addr, 32'h0);
    chk_head("wrap c3", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    cyc(1, 1, 0, 32'h0);
    chk("wrap addr3", imem_addr, 32'h4);
    chk_head("wrap c4", 1'b1, 32'h0, 32'h0);

    // asynchronous reset in the middle of a miss
    cyc(0, 1, 0, 32'h0);
    chk("stall entry addr", imem_addr, 32'h8);
    cyc(0, 1, 0, 32'h0);
    chk("stall held ren", {31'b0, imem_ren}, 32'h1);
    chk("stall held addr", imem_addr, 32'h8);
    #2 reset = 1'b1;
    #1;
    chk("async reset ren", {31'b0, imem_ren}, 32'h0);
    chk("async reset addr", imem_addr, 32'h100);
    chk("async reset count", {29'b0, fifo_count}, 32'h0);
    chk("async reset miss", miss_cycles, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    imem_nostall = 1'b1;
    #1;
    chk("post-reset idle ren", {31'b0, imem_ren}, 32'h0);
    cyc(1, 1, 0, 32'h0);
    chk("post-reset first ren", {31'b0, imem_ren}, 32'h1);
    chk("post-reset first addr", imem_addr, 32'h100);
    cyc(1, 1, 0, 32'h0);

    // miss counter saturates instead of wrapping
    @(negedge clk);
    force dut.miss_q = 32'hFFFF_FFFD;
    #1 release dut.miss_q;
    imem_nostall = 1'b0;
    #1;
    chk("sat preload", miss_cycles, 32'hFFFF_FFFD);
    cyc(0, 1, 0, 32'h0);
    chk("sat step1", miss_cycles, 32'hFFFF_FFFE);
    cyc(0, 1, 0, 32'h0);
    chk("sat step2", miss_cycles, 32'hFFFF_FFFF);
    cyc(0, 1, 0, 32'h0);
    chk("sat hold1", miss_cycles, 32'hFFFF_FFFF);
    cyc(0, 1, 0, 32'h0);
    chk("sat hold2", miss_cycles, 32'hFFFF_FFFF);
    chk("sat addr held", imem_addr, 32'h108);

    // random traffic against a queue model
    @(negedge clk);
    reset = 1'b1;
    mmu_xor = 32'h5A5A_0000;
    @(negedge clk);
    reset = 1'b0;
    m_started = 1'b0;
    m_pending = 1'b0;
    m_pc      = 32'h100;
    m_miss    = 32'h0;
    qpc.delete();
    qin.delete();
    for (int i = 0; i < 600; i++) begin
      if (i > 0) @(negedge clk);
      d  = ($urandom % 20) == 0;
      rp = $urandom;
      n  = ($urandom % 4) != 0;
      r  = ($urandom % 3) != 0;
      imem_nostall   = n;
      id_ready       = r;
      redirect_valid = d;
      redirect_pc    = rp;
      #1;
      e_ren = m_started && !d && (m_pending || qpc.size() < DEPTH);
      chk($sformatf("rnd%0d imem_ren", i), {31'b0, imem_ren}, {31'b0, e_ren});
      chk($sformatf("rnd%0d imem_addr", i), imem_addr, m_pc);
      if (qpc.size() > 0) chk_head($sformatf("rnd%0d", i), 1'b1, qpc[0], qin[0]);
      else                chk_head($sformatf("rnd%0d", i), 1'b0, 32'h0, 32'h0);
      chk($sformatf("rnd%0d fifo_count", i), {29'b0, fifo_count}, qpc.size());
      chk($sformatf("rnd%0d miss_cycles", i), miss_cycles, m_miss);
      if (d) begin
        qpc.delete();
        qin.delete();
        m_pc      = {rp[31:2], 2'b00};
        m_pending = 1'b0;
      end else begin
        if (qpc.size() > 0 && r) begin
          void'(qpc.pop_front());
          void'(qin.pop_front());
        end
        if (e_ren && n) begin
          qpc.push_back(m_pc);
          qin.push_back(m_pc ^ mmu_xor);
          m_pc      = m_pc + 32'd4;
          m_pending = 1'b0;
        end else if (e_ren) begin
          m_pending = 1'b1;
          if (m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 32'd1;
        end
      end
      m_started = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Front-end fetch stage: sits directly upstream of the instruction memory management unit and downstream-feeds the decode stage.
- Owns the program counter and issues word fetches to the instruction MMU.
- Holds each request while the MMU signals a miss (`nostall` low).
- Buffers returned instructions with their PCs in a small FIFO so decode back-pressure does not stall the MMU.
- Handles branch/jump redirects with a full flush.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `DEPTH`, 4: FIFO entries; power of two, 2..16.

Ports:
- `clk`  in  1: clock; all state updates on rising edge.
- `reset`  in  1: reset, asynchronous, active-high.
- `imem_addr`  out  32: fetch address, equal to the PC register; drives MMU `addy`.
- `imem_ren`  out  1: fetch request; drives MMU `ren`. The MMU `wen` is tied 0 and the byte select is tied 4'b1111 at the parent.
- `imem_nostall`  in  1: MMU ready; low means miss in progress.
- `imem_rdata`  in  32: MMU data output; valid in any cycle with `imem_ren && imem_nostall`.
- `redirect_valid`  in  1: control-flow redirect from execute.
- `redirect_pc`  in  32: redirect target; bits [1:0] are forced to 0.
- `id_ready`  in  1: decode accepts the head entry.
- `id_valid`  out  1: FIFO non-empty.
- `id_instr`  out  32: head instruction; 32'h0000_0013 (NOP) when empty.
- `id_pc`  out  32: head PC; 0 when empty.
- `fifo_count`  out  $clog2(DEPTH)+1: occupancy.
- `miss_cycles`  out  32: saturating count of stalled request cycles.

## Operation

FSM states: IDLE, FETCH, STALL.

- **IDLE**
  - Entered on reset; `imem_ren`=0.
  - Always goes to FETCH next cycle.
- **FETCH**
  - `imem_ren` = !full && !redirect_valid.
  - On a request with `imem_nostall`=1, the fetch is accepted: push {pc, imem_rdata}; pc <= pc+4.
  - On a request with `imem_nostall`=0: go to STALL; pc is held.
- **STALL**
  - `imem_ren`=1 and `imem_addr` held, unless `redirect_valid` is asserted.
  - When `imem_nostall` returns to 1: accept (push, pc+4) and go to FETCH.
  - FIFO space is guaranteed, because entry required !full and pops only free space.
- **Redirect** (any state, highest priority)
  - Flush the FIFO (count <= 0).
  - pc <= {redirect_pc[31:2], 2'b00}; state <= FETCH.
  - `imem_ren`=0 in that cycle, so no push occurs.
  - A pop in the same cycle is ignored.
- **Pop:** occurs when `id_valid && id_ready`.
- **Simultaneous push and pop:** count unchanged; the new entry goes behind the others.
- **Full:** push is impossible because `imem_ren`=0. A pop while full frees space, and the request rises in the next cycle, not the same cycle.
- **PC arithmetic:** modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- **`miss_cycles`:** +1 every cycle with `imem_ren && !imem_nostall`; saturates at 32'hFFFF_FFFF.

## Timing

- **Reset values:**
  - pc = RESET_PC; state = IDLE; count = 0.
  - `imem_ren`=0; `id_valid`=0; `id_instr`=32'h13; `id_pc`=0; `miss_cycles`=0.
- **Reset deassertion:** first request is in the second cycle after reset deassertion (the IDLE cycle comes first).
- **Hit throughput:** one instruction per cycle.
- **Hit latency:** request cycle N gives `id_valid` in cycle N+1 (registered FIFO write, combinational head read).
- **Miss:** k stalled cycles add exactly k cycles to latency; the address stays stable throughout.
- **Redirect in cycle N:**
  - `id_valid`=0 in N+1.
  - Target fetched in N+1.
  - Target visible at decode in N+2 on a hit.
- **Reset mid-STALL:** abandons the request immediately (async); the MMU may complete its fill unobserved.
- **Output decode:** `id_*` outputs are combinational from the FIFO head.
- **Registered state:** all other state is registered.

## Test plan

- **Reset and streaming:**
  - Stimulus: RESET_PC=32'h100; MMU always hits, returning data=addr; `id_ready`=1.
  - Required: first request in the 2nd cycle after reset release; decode sees pcs 100,104,108,... with instr equal to pc, one per cycle.
- **Miss hold:**
  - Stimulus: `imem_nostall`=0 for 3 cycles at addr 32'h10C.
  - Required: `imem_addr` held at 10C for 4 cycles; exactly one 10C entry pushed; `miss_cycles`=3; next request 110.
- **Back-pressure/full:**
  - Stimulus: `id_ready`=0, DEPTH=4.
  - Required: `fifo_count` reaches 4, then `imem_ren`=0; one pop re-enables the request next cycle; FIFO order is preserved.
- **Redirect with full FIFO and simultaneous pop:**
  - Stimulus: redirect_pc=32'h2003.
  - Required: count=0 next cycle; next request address 32'h2000; no stale entries appear at decode.
- **Redirect during STALL:**
  - Stimulus: redirect_pc=32'h400 asserted during a miss.
  - Required: `imem_ren`=0 that cycle; next address 400; the old address is never pushed.
- **Wrap and saturation:**
  - Stimulus: redirect to 32'hFFFF_FFF8 and stream.
  - Required: pcs FFF8, FFFC, 0000_0000 in order.
  - Separately, force a long miss and check that `miss_cycles` saturates rather than wraps.
